// File: rtl/alu_sequencer.sv
// alu_sequencer: sequential front end for an external 16-bit combinational ALU.
// Ports: cmd_* valid/ready command input (load immediate or ALU op), alu_* registered
//   operands out and result/flags back in, rsp_* valid/ready result output,
//   dbg_addr/dbg_data combinational register-file read port.
// Latency: load responds the edge after accept; ALU op responds one EXEC cycle later.
// Backpressure: one command in flight; cmd_ready stays low until the response handshakes.
module alu_sequencer #(
  parameter int NREG = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_load,
  input  logic [2:0]  cmd_op,
  input  logic [1:0]  cmd_dst,
  input  logic [1:0]  cmd_srca,
  input  logic [1:0]  cmd_srcb,
  input  logic        cmd_cin,
  input  logic [15:0] cmd_imm,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic        alu_C,
  output logic [2:0]  alu_opcode,
  input  logic [15:0] alu_W,
  input  logic        alu_zer,
  input  logic        alu_neg,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_zer,
  output logic        rsp_neg,
  input  logic [1:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;

  logic [15:0] rf_q [NREG];
  logic [1:0]  dst_q;
  logic [15:0] alu_a_q, alu_b_q;
  logic        alu_c_q;
  logic [2:0]  alu_op_q;
  logic [15:0] rsp_data_q;
  logic        rsp_zer_q, rsp_neg_q;

  // Decoded control from the FSM process.
  logic        alu_issue;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_zer, wr_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, handshake outputs and the single register-file write port.
  // A load writes at its accept edge; an ALU op writes at the EXEC closing edge.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_issue = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = dst_q;
    wr_data   = alu_W;
    wr_zer    = alu_zer;
    wr_neg    = alu_neg;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_load) begin
            wr_en   = 1'b1;
            wr_addr = cmd_dst;
            wr_data = cmd_imm;
            wr_zer  = (cmd_imm == 16'h0000);
            wr_neg  = cmd_imm[15];
            state_d = RESP;
          end else begin
            alu_issue = 1'b1;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        wr_en   = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operands are sampled from the register file before any write at the same
  // edge, so srca == srcb == dst sees the old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= 16'h0000;
      end
      dst_q      <= 2'd0;
      alu_a_q    <= 16'h0000;
      alu_b_q    <= 16'h0000;
      alu_c_q    <= 1'b0;
      alu_op_q   <= 3'd0;
      rsp_data_q <= 16'h0000;
      rsp_zer_q  <= 1'b0;
      rsp_neg_q  <= 1'b0;
    end else begin
      if (alu_issue) begin
        alu_a_q  <= rf_q[cmd_srca];
        alu_b_q  <= rf_q[cmd_srcb];
        alu_c_q  <= cmd_cin;
        alu_op_q <= cmd_op;
        dst_q    <= cmd_dst;
      end
      if (wr_en) begin
        rf_q[wr_addr] <= wr_data;
        rsp_data_q    <= wr_data;
        rsp_zer_q     <= wr_zer;
        rsp_neg_q     <= wr_neg;
      end
    end
  end

  assign alu_A      = alu_a_q;
  assign alu_B      = alu_b_q;
  assign alu_C      = alu_c_q;
  assign alu_opcode = alu_op_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_zer    = rsp_zer_q;
  assign rsp_neg    = rsp_neg_q;
  assign dbg_data   = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer against a behavioural ALU and a scoreboard.
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
// Opcode map of the stand-in ALU: 0 A+B+C, 1 A-B, 2 A&B, 3 B-A, 4 A|B, 5 ~A, 6 shl-in-C, 7 A^B.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_load;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_dst;
  logic [1:0]  cmd_srca;
  logic [1:0]  cmd_srcb;
  logic        cmd_cin;
  logic [15:0] cmd_imm;
  logic [15:0] alu_A;
  logic [15:0] alu_B;
  logic        alu_C;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_W;
  logic        alu_zer;
  logic        alu_neg;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zer;
  logic        rsp_neg;
  logic [1:0]  dbg_addr;
  logic [15:0] dbg_data;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q [$];
  logic [15:0] mdl [4];

  alu_sequencer #(.NREG(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_cin(cmd_cin), .cmd_imm(cmd_imm),
    .alu_A(alu_A), .alu_B(alu_B), .alu_C(alu_C), .alu_opcode(alu_opcode),
    .alu_W(alu_W), .alu_zer(alu_zer), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zer(rsp_zer), .rsp_neg(rsp_neg),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic c);
    case (op)
      3'd0:    alu_fn = a + b + {15'h0, c};
      3'd1:    alu_fn = a - b;
      3'd2:    alu_fn = a & b;
      3'd3:    alu_fn = b - a;
      3'd4:    alu_fn = a | b;
      3'd5:    alu_fn = ~a;
      3'd6:    alu_fn = {a[14:0], c};
      default: alu_fn = a ^ b;
    endcase
  endfunction

  assign alu_W   = alu_fn(alu_opcode, alu_A, alu_B, alu_C);
  assign alu_zer = (alu_W == 16'h0000);
  assign alu_neg = alu_W[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for cmd_ready, presents one command for exactly one accept edge and,
  // when tracked, pushes its expected result and updates the register model.
  task automatic send_cmd(input logic ld, input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] sa, input logic [1:0] sb, input logic cin,
                          input logic [15:0] imm, input bit track);
    logic [15:0] e;
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
      return;
    end
    cmd_load = ld; cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
    cmd_cin = cin; cmd_imm = imm; cmd_valid = 1'b1;
    if (track) begin
      e = ld ? imm : alu_fn(op, mdl[sa], mdl[sb], cin);
      exp_q.push_back(e);
      mdl[dst] = e;
    end
    step();
    cmd_valid = 1'b0;
  endtask

  // Waits for rsp_valid, compares against the scoreboard head, then lets the
  // handshake edge pass (rsp_ready must be 1 when this is called).
  task automatic collect_rsp(input string name);
    logic [15:0] e;
    int n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    total++;
    if (!rsp_valid) begin
      bad++;
      $display("FAIL %s_rsp_timeout: rsp_valid=%0b, required 1", name, rsp_valid);
      return;
    end
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_unexpected_rsp: got data=%h with nothing expected", name, rsp_data);
    end else begin
      e = exp_q.pop_front();
      if ({rsp_data, rsp_zer, rsp_neg} !== {e, (e == 16'h0000), e[15]}) begin
        bad++;
        $display("FAIL %s_rsp: got data=%h zer=%0b neg=%0b, required data=%h zer=%0b neg=%0b",
                 name, rsp_data, rsp_zer, rsp_neg, e, (e == 16'h0000), e[15]);
      end
    end
    step();
  endtask

  task automatic check_reg(input string name, input logic [1:0] a, input logic [15:0] e);
    dbg_addr = a;
    #1;
    total++;
    if (dbg_data !== e) begin
      bad++;
      $display("FAIL %s: dbg_data[R%0d]=%h, required %h", name, a, dbg_data, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0; cmd_dst = 2'd0;
    cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_cin = 1'b0; cmd_imm = 16'h0;
    rsp_ready = 1'b1; dbg_addr = 2'd0;
    for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
    step(); step();
    total++;
    if ({rsp_valid, alu_A, alu_B, alu_C, alu_opcode, rsp_data, rsp_zer, rsp_neg} !== 55'h0) begin
      bad++;
      $display("FAIL reset_outputs: rsp_valid=%0b A=%h B=%h C=%0b op=%0d data=%h zer=%0b neg=%0b, required all 0",
               rsp_valid, alu_A, alu_B, alu_C, alu_opcode, rsp_data, rsp_zer, rsp_neg);
    end
    rst_n = 1'b1;
    step();
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: cmd_ready=%0b rsp_valid=%0b, required 1/0", cmd_ready, rsp_valid);
    end
    for (int i = 0; i < 4; i++) check_reg("reset_reg", 2'(i), 16'h0000);
  endtask

  task automatic test_add_carry();
    send_cmd(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 16'd5, 1'b1);
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL load_rsp_timing: rsp_valid=%0b right after accept, required 1", rsp_valid);
    end
    check_reg("load_visible", 2'd0, 16'd5);
    collect_rsp("load_r0");
    send_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 16'd3, 1'b1);
    collect_rsp("load_r1");
    send_cmd(1'b0, 3'd0, 2'd2, 2'd0, 2'd1, 1'b1, 16'h0, 1'b1);
    total++;
    if ({alu_A, alu_B, alu_C, alu_opcode, rsp_valid, cmd_ready} !== {16'd5, 16'd3, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add_exec: A=%h B=%h C=%0b op=%0d rsp_valid=%0b cmd_ready=%0b, required 0005 0003 1 0 0 0",
               alu_A, alu_B, alu_C, alu_opcode, rsp_valid, cmd_ready);
    end
    collect_rsp("add_carry");
    check_reg("add_writeback", 2'd2, 16'd9);
  endtask

  task automatic test_negative();
    send_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 16'hFFF8, 1'b1);
    collect_rsp("load_neg8");
    send_cmd(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 16'hFFFE, 1'b1);
    collect_rsp("load_neg2");
    send_cmd(1'b0, 3'd3, 2'd3, 2'd3, 2'd1, 1'b0, 16'h0, 1'b1);
    collect_rsp("op3_negative");
    check_reg("op3_writeback", 2'd3, 16'hFFFA);
  endtask

  task automatic test_zero_inplace();
    send_cmd(1'b0, 3'd7, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0, 1'b1);
    collect_rsp("op7_zero");
    check_reg("op7_writeback", 2'd0, 16'h0000);
    send_cmd(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 1'b0, 16'h0004, 1'b1);
    collect_rsp("load_r1_4");
    send_cmd(1'b0, 3'd0, 2'd1, 2'd1, 2'd1, 1'b0, 16'h0, 1'b1);
    collect_rsp("inplace_add");
    check_reg("inplace_writeback", 2'd1, 16'h0008);
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    send_cmd(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 1'b0, 16'h1234, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({rsp_valid, cmd_ready, rsp_data, rsp_zer, rsp_neg} !== {1'b1, 1'b0, 16'h1234, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold%0d: valid=%0b ready=%0b data=%h zer=%0b neg=%0b, required 1 0 1234 0 0",
                 i, rsp_valid, cmd_ready, rsp_data, rsp_zer, rsp_neg);
      end
      // A command offered while busy must be dropped without touching R2.
      cmd_load = 1'b1; cmd_dst = 2'd2; cmd_imm = 16'hDEAD; cmd_valid = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    check_reg("bp_ignored_cmd", 2'd2, mdl[2]);
    rsp_ready = 1'b1;
    collect_rsp("bp_release");
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle: cmd_ready=%0b rsp_valid=%0b after handshake, required 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_exec();
    send_cmd(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 1'b0, 16'd9, 1'b1);
    collect_rsp("load_r2_9");
    // Untracked: this command must never respond (result would be 19).
    send_cmd(1'b0, 3'd0, 2'd2, 2'd2, 2'd2, 1'b1, 16'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, alu_A, alu_C} !== 18'h0) begin
      bad++;
      $display("FAIL midexec_async: rsp_valid=%0b A=%h C=%0b during reset, required 0", rsp_valid, alu_A, alu_C);
    end
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
    step();
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL midexec_ready: cmd_ready=%0b after release, required 1", cmd_ready);
    end
    check_reg("midexec_no_writeback", 2'd2, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL midexec_no_rsp: rsp_valid=%0b in cycle %0d after reset, required 0", rsp_valid, i);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic       ld;
    logic [2:0] op;
    logic [1:0] dst, sa, sb;
    logic       cin;
    logic [15:0] imm, ea, eb;
    for (int i = 0; i < 24; i++) begin
      ld  = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 7));
      dst = (i < 4) ? 2'(i) : 2'($urandom_range(0, 3));
      sa  = 2'($urandom_range(0, 3));
      sb  = 2'($urandom_range(0, 3));
      cin = 1'($urandom_range(0, 1));
      imm = 16'($urandom);
      ea  = mdl[sa];
      eb  = mdl[sb];
      send_cmd(ld, op, dst, sa, sb, cin, imm, 1'b1);
      if (!ld) begin
        total++;
        if ({alu_A, alu_B, alu_C, alu_opcode} !== {ea, eb, cin, op}) begin
          bad++;
          $display("FAIL b2b_operands%0d: A=%h B=%h C=%0b op=%0d, required %h %h %0b %0d",
                   i, alu_A, alu_B, alu_C, alu_opcode, ea, eb, cin, op);
        end
      end
      collect_rsp("b2b");
    end
    for (int i = 0; i < 4; i++) check_reg("b2b_regfile", 2'(i), mdl[i]);
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_negative();
    test_zero_inplace();
    test_backpressure();
    test_reset_mid_exec();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
